// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write bus driven by the UART boot loader.
interface imem_uart_loader_if #(
    parameter int ADDR_W = 6
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader for the instruction memory.
// Frame: N, then N little-endian 32-bit words, then XOR checksum of all
// preceding bytes. The CPU stays held in reset until a frame checks out.
//
// Receiver states:
//   R_IDLE  | waiting for a low level on the synchronized line
//   R_START | half-bit wait, then confirm the start bit (else glitch)
//   R_DATA  | eight mid-bit samples, LSB first
//   R_STOP  | mid-stop-bit sample: high = byte valid, low = framing error
// Loader states:
//   L_LEN   | next byte is the word count N
//   L_DATA  | assembling words, one write per 4 bytes
//   L_CSUM  | next byte must equal the running XOR
//   L_DONE  | image valid, CPU released, bytes ignored
//   L_ERR   | image rejected, CPU held, bytes ignored
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                start,
    imem_uart_loader_if.master  imem,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MAX_WORDS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rstate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       rx_byte_q;
    logic             byte_valid_q, frame_err_q;

    ld_state_t         lstate_q;
    logic [ADDR_W:0]   len_q, index_q, words_q;
    logic [ADDR_W:0]   index_d;
    logic [7:0]        csum_q;
    logic [1:0]        byte_cnt_q;
    logic              we_q, done_q, err_q, hold_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    assign index_d = index_q + 1'b1;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Byte receiver: down-counter times each sample to the middle of a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q     <= R_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rstate_q)
                R_IDLE: begin
                    if (!rx_sync_q) begin
                        rstate_q <= R_START;
                        cnt_q    <= CNT_HALF;
                    end
                end
                R_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_sync_q) begin
                            rstate_q  <= R_DATA;
                            cnt_q     <= CNT_FULL;
                            bit_idx_q <= '0;
                        end else begin
                            rstate_q <= R_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == '0) begin
                        rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                        cnt_q     <= CNT_FULL;
                        if (bit_idx_q == 3'd7) begin
                            rstate_q <= R_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_q == '0) begin
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= ~rx_sync_q;
                        rstate_q     <= R_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // Frame loader: length check, word assembly/writes, checksum, status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lstate_q   <= L_LEN;
            len_q      <= '0;
            index_q    <= '0;
            words_q    <= '0;
            csum_q     <= '0;
            byte_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                // A byte arriving in the same cycle is dropped on purpose.
                lstate_q   <= L_LEN;
                index_q    <= '0;
                words_q    <= '0;
                csum_q     <= '0;
                byte_cnt_q <= '0;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                hold_q     <= 1'b1;
            end else if (frame_err_q &&
                         (lstate_q == L_LEN || lstate_q == L_DATA || lstate_q == L_CSUM)) begin
                lstate_q <= L_ERR;
                err_q    <= 1'b1;
                hold_q   <= 1'b1;
            end else if (byte_valid_q) begin
                case (lstate_q)
                    L_LEN: begin
                        if (rx_byte_q == 8'd0 || int'(rx_byte_q) > MAX_WORDS) begin
                            lstate_q <= L_ERR;
                            err_q    <= 1'b1;
                            hold_q   <= 1'b1;
                        end else begin
                            len_q      <= (ADDR_W+1)'(rx_byte_q);
                            csum_q     <= rx_byte_q;
                            index_q    <= '0;
                            byte_cnt_q <= '0;
                            lstate_q   <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        wdata_q    <= {rx_byte_q, wdata_q[31:8]};
                        csum_q     <= csum_q ^ rx_byte_q;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= index_q[ADDR_W-1:0];
                            index_q <= index_d;
                            words_q <= words_q + 1'b1;
                            if (index_d == len_q) begin
                                lstate_q <= L_CSUM;
                            end
                        end
                    end
                    L_CSUM: begin
                        if (rx_byte_q == csum_q) begin
                            lstate_q <= L_DONE;
                            done_q   <= 1'b1;
                            hold_q   <= 1'b0;
                        end else begin
                            lstate_q <= L_ERR;
                            err_q    <= 1'b1;
                            hold_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign cpu_hold        = hold_q;
    assign load_done       = done_q;
    assign load_err        = err_q;
    assign words_loaded    = words_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for the UART instruction-memory loader (4-clock bit period).
module tb_imem_uart_loader;
    localparam int CPB = 4;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          start = 1'b0;
    logic          cpu_hold, load_done, load_err;
    logic [AW:0]   words_loaded;

    imem_uart_loader_if #(.ADDR_W(AW)) bus ();

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .start        (start),
        .imem         (bus.master),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Write log and back-to-back strobe detector, sampled mid-cycle.
    int          wr_cnt = 0;
    int          we_b2b = 0;
    logic        prev_we = 1'b0;
    logic [AW-1:0] wr_addr [256];
    logic [31:0]   wr_data [256];
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr[wr_cnt % 256] = bus.imem_addr;
            wr_data[wr_cnt % 256] = bus.imem_wdata;
            wr_cnt++;
            if (prev_we === 1'b1) we_b2b++;
        end
        prev_we = bus.imem_we;
    end

    typedef struct {
        string       name;
        logic [95:0] bytes;
        int          n;
        int          bad_stop;
        logic        exp_done;
        logic        exp_err;
        logic        exp_hold;
        int          exp_words;
        int          exp_nwr;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_lvl);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [95:0] fb, input int n, input int bad_stop);
        for (int i = 0; i < n; i++) send_byte(fb[8*i +: 8], (i != bad_stop));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(2);
    endtask

    localparam logic [95:0] HAPPY = 96'h92_00_10_00_93_00_00_00_13_02;

    initial begin
        int base;
        vecs[0] = '{"happy",     HAPPY,                                10, -1, 1'b1, 1'b0, 1'b0, 2, 2, 32'h00000013, 32'h00100093};
        vecs[1] = '{"bad_csum",  96'h00_00_10_00_93_00_00_00_13_02,    10, -1, 1'b0, 1'b1, 1'b1, 2, 2, 32'h00000013, 32'h00100093};
        vecs[2] = '{"len_zero",  96'h00,                                1, -1, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'h0};
        vecs[3] = '{"len_65",    96'h41,                                1, -1, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'h0};
        vecs[4] = '{"framing",   HAPPY,                                10,  2, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'h0};
        vecs[5] = '{"recover",   HAPPY,                                10, -1, 1'b1, 1'b0, 1'b0, 2, 2, 32'h00000013, 32'h00100093};
        vecs[6] = '{"one_word",  96'h09_12_34_56_78_01,                 6, -1, 1'b1, 1'b0, 1'b0, 1, 1, 32'h12345678, 32'h0};

        rst = 1'b1;
        #7;
        chk("rst_we",    32'(bus.imem_we), 32'd0);
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_done",  32'(load_done), 32'd0);
        chk("rst_err",   32'(load_err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        #10;
        rst = 1'b0;
        idle(3);

        for (int v = 0; v < 7; v++) begin
            pulse_start();
            chk({vecs[v].name, "_clr_done"}, 32'(load_done), 32'd0);
            chk({vecs[v].name, "_clr_err"},  32'(load_err), 32'd0);
            base = wr_cnt;
            send_frame(vecs[v].bytes, vecs[v].n, vecs[v].bad_stop);
            idle(60);
            chk({vecs[v].name, "_done"},  32'(load_done), 32'(vecs[v].exp_done));
            chk({vecs[v].name, "_err"},   32'(load_err), 32'(vecs[v].exp_err));
            chk({vecs[v].name, "_hold"},  32'(cpu_hold), 32'(vecs[v].exp_hold));
            chk({vecs[v].name, "_words"}, 32'(words_loaded), 32'(vecs[v].exp_words));
            chk({vecs[v].name, "_nwr"},   32'(wr_cnt - base), 32'(vecs[v].exp_nwr));
            if (vecs[v].exp_nwr > 0 && wr_cnt - base > 0) begin
                chk({vecs[v].name, "_a0"}, 32'(wr_addr[base % 256]), 32'd0);
                chk({vecs[v].name, "_d0"}, wr_data[base % 256], vecs[v].exp_d0);
            end
            if (vecs[v].exp_nwr > 1 && wr_cnt - base > 1) begin
                chk({vecs[v].name, "_a1"}, 32'(wr_addr[(base + 1) % 256]), 32'd1);
                chk({vecs[v].name, "_d1"}, wr_data[(base + 1) % 256], vecs[v].exp_d1);
            end
        end

        // Glitch on an idle line must not produce a byte.
        pulse_start();
        base = wr_cnt;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(40);
        chk("glitch_err",   32'(load_err), 32'd0);
        chk("glitch_done",  32'(load_done), 32'd0);
        chk("glitch_words", 32'(words_loaded), 32'd0);
        chk("glitch_nwr",   32'(wr_cnt - base), 32'd0);
        send_frame(HAPPY, 10, -1);
        idle(60);
        chk("glitch_then_done",  32'(load_done), 32'd1);
        chk("glitch_then_words", 32'(words_loaded), 32'd2);

        // Abort after a partial word; the next frame restarts at address 0.
        pulse_start();
        base = wr_cnt;
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(4);
        pulse_start();
        chk("abort_nwr_mid", 32'(wr_cnt - base), 32'd0);
        chk("abort_words",   32'(words_loaded), 32'd0);
        send_frame(HAPPY, 10, -1);
        idle(60);
        chk("abort_nwr", 32'(wr_cnt - base), 32'd2);
        if (wr_cnt - base > 0) begin
            chk("abort_a0", 32'(wr_addr[base % 256]), 32'd0);
            chk("abort_d0", wr_data[base % 256], 32'h00000013);
        end
        chk("abort_done", 32'(load_done), 32'd1);

        // Asynchronous reset in the middle of a byte.
        rx = 1'b0;
        idle(6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we",    32'(bus.imem_we), 32'd0);
        chk("arst_addr",  32'(bus.imem_addr), 32'd0);
        chk("arst_wdata", bus.imem_wdata, 32'd0);
        chk("arst_hold",  32'(cpu_hold), 32'd1);
        chk("arst_done",  32'(load_done), 32'd0);
        chk("arst_err",   32'(load_err), 32'd0);
        chk("arst_words", 32'(words_loaded), 32'd0);
        rx = 1'b1;
        #20;
        rst = 1'b0;
        idle(60);
        chk("post_rst_hold", 32'(cpu_hold), 32'd1);
        chk("post_rst_err",  32'(load_err), 32'd0);

        chk("we_single_cycle", 32'(we_b2b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
Serial boot loader that writes the instruction memory the RV32 datapath fetches from. It receives an 8N1 UART byte stream and assembles little-endian 32-bit words. Each word is written to consecutive instruction-memory word addresses, and the frame is validated with an XOR checksum. The CPU is held in reset (cpu_hold) until a valid image has been loaded.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4
ADDR_W, 6, instruction-memory word-address width (64 words, matching pcout[7:2])

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rx  input  1  UART serial input, idle high, asynchronous to clk
start  input  1  one-cycle pulse: abort any load, clear status, re-arm for a new frame
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
cpu_hold  output  1  1 = keep CPU in reset
load_done  output  1  valid image loaded (sticky until start/rst)
load_err  output  1  length, framing or checksum error (sticky until start/rst)
words_loaded  output  ADDR_W+1  count of words written in the current frame

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, including mid-frame.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0, loader in LEN, receiver in IDLE, sync flops=1.
- rx passes through a 2-flop synchronizer reset to 1. All sampling uses the synchronized value.
- Receiver FSM (8N1, LSB first):
  - IDLE: a synchronized 0 starts START.
  - START: counts CLKS_PER_BIT/2 cycles, then resamples. If 0, go to DATA; if 1, it was a glitch, return to IDLE.
  - DATA: 8 samples, each CLKS_PER_BIT cycles apart (mid-bit).
  - STOP: samples after CLKS_PER_BIT cycles. If 1, pulse byte_valid for one cycle. If 0, flag a framing error. Either way, return to IDLE.
- Loader FSM, LEN:
  - The first byte is N.
  - N=0 or N>2^ADDR_W goes to ERR.
  - Otherwise: latch N, set csum=N, index=0, go to DATA.
- Loader FSM, DATA:
  - Each byte shifts in as imem_wdata <= {byte, imem_wdata[31:8]}, and csum ^= byte.
  - On the 4th byte of a word: imem_we=1 for exactly the next cycle, with imem_addr=index and imem_wdata holding the complete word. index and words_loaded then increment.
  - When index reaches N, go to CSUM.
- Loader FSM, CSUM:
  - Received byte == csum goes to DONE; otherwise ERR.
- Loader FSM, DONE:
  - load_done=1, cpu_hold=0.
  - Further bytes are ignored.
- Loader FSM, ERR:
  - load_err=1, cpu_hold=1.
  - Further bytes are ignored.
  - Words already written are not rolled back.
- A framing error in LEN, DATA or CSUM goes to ERR.
- start (any state, highest priority after rst):
  - Loader goes to LEN with index=0, words_loaded=0, csum=0 and a partially assembled word discarded.
  - load_done=0, load_err=0, cpu_hold=1 from the next cycle.
  - The receiver FSM is unaffected.
- start coinciding with byte_valid: start wins and the byte is dropped.
- imem_addr holds its last written value between writes. imem_we is never high for two consecutive cycles.

Test Plan:
Bench uses CLKS_PER_BIT=4, ADDR_W=6, 4-cycle bit periods.

1. Happy path. After rst, send bytes 02 13 00 00 00 93 00 10 00 92.
   -> write addr0=0x00000013, then addr1=0x00100093, each a single-cycle imem_we.
   -> words_loaded=2, load_done=1, cpu_hold=0, load_err=0.
2. Bad checksum. Same frame with final byte 00.
   -> both writes occur, then load_err=1, cpu_hold=1, load_done=0.
3. Bad length. Send 00 -> load_err=1, no imem_we. After start, send 41 (65) -> load_err=1, no writes.
4. Framing error. In test-1 frame, drive the stop bit of the 3rd byte low.
   -> load_err=1, no writes, cpu_hold=1.
   -> Then start + the full valid frame -> load_done=1.
5. Glitch rejection. Pulse rx low for 1 cycle while idle -> no byte_valid, state unchanged. A subsequent valid frame loads correctly.
6. Abort and reset.
   - Pulse start after 02 13 00 -> no write. Then send the full test-1 frame -> writes start at addr0 and load_done=1.
   - Separately, assert rst mid-byte -> all outputs return to their reset values in the same cycle.
